// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared definitions for the MEM-stage data port responder.
//   - Datatype encoding (identical to what the Controller drives on Datatype)
//   - Responder FSM state encoding
//   - Lane-steering helpers used for stores (byte enables, data replication)
//     and loads (lane extraction with sign extension)
// -----------------------------------------------------------------------------
package mem_pkg;

  // Access size encoding on ReqDatatype.
  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;
  localparam logic [1:0] DT_RSVD = 2'b11;

  // Wait counter width; WAIT_STATES is limited to 0..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte enables for a store of size dt at byte offset lane (little-endian).
  function automatic logic [3:0] byte_enables(input logic [1:0] dt,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (dt)
      DT_WORD: be = 4'b1111;
      DT_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      DT_BYTE: be = 4'b0001 << lane;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across lanes so the byte enables
  // alone decide which lanes are written.
  function automatic logic [31:0] store_lanes(input logic [1:0]  dt,
                                              input logic [31:0] wdata);
    logic [31:0] d;
    case (dt)
      DT_HALF: d = {2{wdata[15:0]}};
      DT_BYTE: d = {4{wdata[7:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half out of a RAM word and sign-extend it.
  function automatic logic [31:0] load_extract(input logic [1:0]  dt,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (dt)
      DT_WORD: d = word;
      DT_HALF: d = {{16{h[15]}}, h};
      DT_BYTE: d = {{24{b[7]}}, b};
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage : mem_pkg

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if: request/response bus between the MEM stage (master)
// and the data memory responder (slave).
//   ReqValid/ReqReady  valid/ready handshake for one load or store
//   ReqWrite           1 = store, 0 = load
//   ReqAddr            byte address
//   ReqWData           store data, right-justified for byte and half
//   ReqDatatype        00 word, 01 half, 10 byte, 11 reserved
//   RspValid           one-cycle response strobe
//   RspRData           sign-extended load data (0 for stores and errors)
//   RspErr             access error, valid with RspValid
//   Stall              pipeline hold request back to the core
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [1:0]  ReqDatatype;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        RspErr;
  logic        Stall;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqDatatype,
    input  ReqReady, RspValid, RspRData, RspErr, Stall
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqDatatype,
    output ReqReady, RspValid, RspRData, RspErr, Stall
  );
endinterface : data_mem_responder_if

// File: rtl/data_mem_responder_byte_lane_ram.sv
// -----------------------------------------------------------------------------
// byte_lane_ram: DEPTH_WORDS x 32 data array, byte-enable synchronous write,
// combinational read. Kept separate so it can be swapped for a block-RAM
// primitive.
//   Clk      rising-edge clock
//   i_we     per-byte write enables (bit n writes bits 8n+7:8n)
//   i_waddr  write word index
//   i_wdata  write data (already lane-steered)
//   i_raddr  read word index
//   o_rdata  read data, combinational
// -----------------------------------------------------------------------------
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          Clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; clearing it would forbid mapping
  // to block RAM, and contents must survive a pipeline reset anyway.
  always_ff @(posedge Clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : byte_lane_ram

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder: memory-side responder for the MEM-stage data port.
// Accepts one load/store at a time, inserts WAIT_STATES wait cycles, performs
// byte/half/word lane steering with sign-extended loads, flags misaligned or
// out-of-range accesses, and stalls the pipeline until the response cycle.
//   Clk   rising-edge clock
//   Rst   synchronous, active-low reset (memory contents are kept)
//   bus   data_mem_responder_if slave port (request, response, Stall)
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two
//   WAIT_STATES  extra cycles between accept and response, 0..15
// -----------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned    AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  // FSM and latched request
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_dt;

  // Registered outputs
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  // Request currently being serviced
  logic              w_cur_write;
  logic [31:0]       w_cur_addr;
  logic [31:0]       w_cur_wdata;
  logic [1:0]        w_cur_dt;

  logic              w_handshake;
  logic              w_enter_resp;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;
  logic [31:0]       w_load_data;
  logic [AW-1:0]     w_word_idx;

  assign w_handshake = (r_state == ST_IDLE) && bus.ReqValid && r_req_ready;

  // Response is entered straight from IDLE only with zero wait states;
  // otherwise on the last WAIT cycle.
  assign w_enter_resp = ((r_state == ST_IDLE) && w_handshake && (WAIT_STATES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt <= CNT_W'(1)));

  // With zero wait states the commit and read happen on the accept edge,
  // before the latch is loaded, so the live bus is used in IDLE. In every
  // other state only the latched copy is used, which makes the bus a
  // don't-care while waiting.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on any path.
  always_comb begin
    w_cur_write = r_write;
    w_cur_addr  = r_addr;
    w_cur_wdata = r_wdata;
    w_cur_dt    = r_dt;
    if (r_state == ST_IDLE) begin
      w_cur_write = bus.ReqWrite;
      w_cur_addr  = bus.ReqAddr;
      w_cur_wdata = bus.ReqWData;
      w_cur_dt    = bus.ReqDatatype;
    end
  end

  assign w_err = (w_cur_dt == DT_RSVD) ||
                 ((w_cur_dt == DT_HALF) && w_cur_addr[0]) ||
                 ((w_cur_dt == DT_WORD) && (w_cur_addr[1:0] != 2'b00)) ||
                 ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_word_idx  = w_cur_addr[AW+1:2];
  assign w_ram_wdata = store_lanes(w_cur_dt, w_cur_wdata);

  // Gating with Rst drops a store whose commit edge coincides with reset.
  assign w_be = (Rst && w_enter_resp && w_cur_write && !w_err)
              ? byte_enables(w_cur_dt, w_cur_addr[1:0]) : 4'b0000;

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .Clk     (Clk),
    .i_we    (w_be),
    .i_waddr (w_word_idx),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_word_idx),
    .o_rdata (w_ram_rdata)
  );

  assign w_load_data = load_extract(w_cur_dt, w_cur_addr[1:0], w_ram_rdata);

  // NOTE: all state is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_dt        <= DT_WORD;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_write     <= bus.ReqWrite;
            r_addr      <= bus.ReqAddr;
            r_wdata     <= bus.ReqWData;
            r_dt        <= bus.ReqDatatype;
            r_cnt       <= WAIT_CNT;
            r_req_ready <= 1'b0;
            r_state     <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_enter_resp) begin
            r_cnt   <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
      endcase

      // Response data is captured on entry to RESP and held for that cycle.
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_cur_write || w_err) ? 32'h0 : w_load_data;
      end
    end
  end

  assign bus.ReqReady = r_req_ready;
  assign bus.RspValid = r_rsp_valid;
  assign bus.RspErr   = r_rsp_err;
  assign bus.RspRData = r_rsp_rdata;

  // Stall must rise in the same cycle the request is presented, so it is
  // decoded from the state and the live ReqValid rather than registered.
  assign bus.Stall = ((r_state == ST_IDLE) && bus.ReqValid) || (r_state == ST_WAIT);

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder: directed self-checking bench for data_mem_responder.
// u_dut runs with WAIT_STATES=2, u_dut0 with WAIT_STATES=0 (back-to-back).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [1:0] T_WORD = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_BYTE = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus  ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stalls;
    logic        rdy_req;
    logic        rdy_resp;
    logic        valid_after;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_STATES=2 port. The request is driven just after
  // edge E; the response is expected to be seen after edge E+3.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] dt, input logic perturb, output rsp_t r);
    r.rdata       = 'x;
    r.err         = 1'bx;
    r.lat         = -1;
    r.stalls      = 0;
    r.rdy_resp    = 1'b1;
    r.valid_after = 1'b1;
    @(posedge clk);
    #1;
    bus.ReqWrite    = wr;
    bus.ReqAddr     = addr;
    bus.ReqWData    = wdata;
    bus.ReqDatatype = dt;
    bus.ReqValid    = 1'b1;
    @(negedge clk);
    r.rdy_req = bus.ReqReady;
    if (bus.Stall) r.stalls++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      if (k == 1) begin
        #1;
        bus.ReqValid = 1'b0;
        if (perturb) begin
          bus.ReqAddr  = addr ^ 32'h0000_0080;
          bus.ReqWData = ~wdata;
        end
      end
      @(negedge clk);
      if (bus.Stall) r.stalls++;
      if (bus.RspValid) begin
        r.lat      = k;
        r.rdata    = bus.RspRData;
        r.err      = bus.RspErr;
        r.rdy_resp = bus.ReqReady;
        break;
      end
    end
    if (r.lat > 0) begin
      @(negedge clk);
      r.valid_after = bus.RspValid;
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] dt, input logic perturb,
                     input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t r;
    access(wr, addr, wdata, dt, perturb, r);
    check($sformatf("%s.rdata", tag),    r.rdata,           exp_rdata);
    check($sformatf("%s.err", tag),      {31'b0, r.err},    {31'b0, exp_err});
    check($sformatf("%s.latency", tag),  32'(r.lat),        32'd3);
    check($sformatf("%s.stalls", tag),   32'(r.stalls),     32'd3);
    check($sformatf("%s.rdy_req", tag),  {31'b0, r.rdy_req},     32'd1);
    check($sformatf("%s.rdy_resp", tag), {31'b0, r.rdy_resp},    32'd0);
    check($sformatf("%s.one_shot", tag), {31'b0, r.valid_after}, 32'd0);
  endtask

  task automatic drive0(input vec_t v);
    bus0.ReqWrite    = v.wr;
    bus0.ReqAddr     = v.addr;
    bus0.ReqWData    = v.wdata;
    bus0.ReqDatatype = v.dt;
    bus0.ReqValid    = 1'b1;
  endtask

  initial begin
    vec_t v0 [6];
    int   seen;

    bus.ReqValid     = 1'b0;
    bus.ReqWrite     = 1'b0;
    bus.ReqAddr      = '0;
    bus.ReqWData     = '0;
    bus.ReqDatatype  = T_WORD;
    bus0.ReqValid    = 1'b0;
    bus0.ReqWrite    = 1'b0;
    bus0.ReqAddr     = '0;
    bus0.ReqWData    = '0;
    bus0.ReqDatatype = T_WORD;

    // ---- reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ReqReady", {31'b0, bus.ReqReady}, 32'd1);
    check("reset.RspValid", {31'b0, bus.RspValid}, 32'd0);
    check("reset.RspErr",   {31'b0, bus.RspErr},   32'd0);
    check("reset.RspRData", bus.RspRData,          32'h0);
    check("reset.Stall",    {31'b0, bus.Stall},    32'd0);
    rst = 1'b1;

    // ---- word store / load
    run("st_w10", 1'b1, 32'h10, 32'hDEAD_BEEF, T_WORD, 1'b0, 32'h0,         1'b0);
    run("ld_w10", 1'b0, 32'h10, 32'h0,         T_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // ---- byte/half lane steering and sign extension
    run("st_w20", 1'b1, 32'h20, 32'h1122_3344, T_WORD, 1'b0, 32'h0,         1'b0);
    run("st_b21", 1'b1, 32'h21, 32'hAAAA_AA80, T_BYTE, 1'b0, 32'h0,         1'b0);
    run("st_h22", 1'b1, 32'h22, 32'h5555_7FFE, T_HALF, 1'b0, 32'h0,         1'b0);
    run("ld_w20", 1'b0, 32'h20, 32'h0,         T_WORD, 1'b0, 32'h7FFE_8044, 1'b0);
    run("ld_b21", 1'b0, 32'h21, 32'h0,         T_BYTE, 1'b0, 32'hFFFF_FF80, 1'b0);
    run("ld_h22", 1'b0, 32'h22, 32'h0,         T_HALF, 1'b0, 32'h0000_7FFE, 1'b0);
    run("ld_b20", 1'b0, 32'h20, 32'h0,         T_BYTE, 1'b0, 32'h0000_0044, 1'b0);
    run("ld_h20", 1'b0, 32'h20, 32'h0,         T_HALF, 1'b0, 32'hFFFF_8044, 1'b0);
    run("ld_b23", 1'b0, 32'h23, 32'h0,         T_BYTE, 1'b0, 32'h0000_007F, 1'b0);

    // ---- error cases
    run("ld_h13_mis",  1'b0, 32'h13,   32'h0,         T_HALF, 1'b0, 32'h0,         1'b1);
    run("st_w14",      1'b1, 32'h14,   32'hCAFE_F00D, T_WORD, 1'b0, 32'h0,         1'b0);
    run("st_w16_mis",  1'b1, 32'h16,   32'h0000_0055, T_WORD, 1'b0, 32'h0,         1'b1);
    run("ld_w14",      1'b0, 32'h14,   32'h0,         T_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);
    run("ld_rsvd",     1'b0, 32'h10,   32'h0,         T_RSVD, 1'b0, 32'h0,         1'b1);
    run("st_w00",      1'b1, 32'h0,    32'h0BAD_F00D, T_WORD, 1'b0, 32'h0,         1'b0);
    run("st_w1000_oor",1'b1, 32'h1000, 32'h1111_1111, T_WORD, 1'b0, 32'h0,         1'b1);
    run("ld_w00",      1'b0, 32'h0,    32'h0,         T_WORD, 1'b0, 32'h0BAD_F00D, 1'b0);
    run("ld_w1000_oor",1'b0, 32'h1000, 32'h0,         T_WORD, 1'b0, 32'h0,         1'b1);
    run("st_wffc",     1'b1, 32'hFFC,  32'h89AB_CDEF, T_WORD, 1'b0, 32'h0,         1'b0);
    run("ld_wffc",     1'b0, 32'hFFC,  32'h0,         T_WORD, 1'b0, 32'h89AB_CDEF, 1'b0);

    // ---- request inputs changed while waiting
    run("st_wb0",      1'b1, 32'hB0, 32'h0000_B0B0, T_WORD, 1'b0, 32'h0,         1'b0);
    run("st_w30_pert", 1'b1, 32'h30, 32'h1357_9BDF, T_WORD, 1'b1, 32'h0,         1'b0);
    run("ld_w30",      1'b0, 32'h30, 32'h0,         T_WORD, 1'b0, 32'h1357_9BDF, 1'b0);
    run("ld_wb0",      1'b0, 32'hB0, 32'h0,         T_WORD, 1'b0, 32'h0000_B0B0, 1'b0);
    run("ld_w30_pert", 1'b0, 32'h30, 32'h0,         T_WORD, 1'b1, 32'h1357_9BDF, 1'b0);

    // ---- reset during WAIT of a store
    run("st_w40_old", 1'b1, 32'h40, 32'hAAAA_5555, T_WORD, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    bus.ReqWrite    = 1'b1;
    bus.ReqAddr     = 32'h40;
    bus.ReqWData    = 32'h1234_5678;
    bus.ReqDatatype = T_WORD;
    bus.ReqValid    = 1'b1;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    @(negedge clk);
    check("rst_mid.stall_in_wait", {31'b0, bus.Stall}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.ReqReady", {31'b0, bus.ReqReady}, 32'd1);
    check("rst_mid.RspValid", {31'b0, bus.RspValid}, 32'd0);
    check("rst_mid.Stall",    {31'b0, bus.Stall},    32'd0);
    check("rst_mid.RspErr",   {31'b0, bus.RspErr},   32'd0);
    rst  = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.RspValid) seen++;
    end
    check("rst_mid.no_late_rsp", 32'(seen), 32'd0);
    run("ld_w40_after_rst", 1'b0, 32'h40, 32'h0, T_WORD, 1'b0, 32'hAAAA_5555, 1'b0);

    // ---- zero wait states, ReqValid held high back to back
    v0[0] = '{1'b1, 32'h50, 32'h0102_0304, T_WORD, 32'h0,         1'b0};
    v0[1] = '{1'b0, 32'h50, 32'h0,         T_WORD, 32'h0102_0304, 1'b0};
    v0[2] = '{1'b1, 32'h52, 32'h1234_56EE, T_BYTE, 32'h0,         1'b0};
    v0[3] = '{1'b0, 32'h50, 32'h0,         T_WORD, 32'h01EE_0304, 1'b0};
    v0[4] = '{1'b0, 32'h52, 32'h0,         T_BYTE, 32'hFFFF_FFEE, 1'b0};
    v0[5] = '{1'b0, 32'h51, 32'h0,         T_HALF, 32'h0,         1'b1};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        @(posedge clk);
        #1;
        drive0(v0[0]);
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
      check($sformatf("ws0[%0d].idle_ready", i), {31'b0, bus0.ReqReady}, 32'd1);
      check($sformatf("ws0[%0d].idle_valid", i), {31'b0, bus0.RspValid}, 32'd0);
      check($sformatf("ws0[%0d].idle_stall", i), {31'b0, bus0.Stall},    32'd1);
      @(posedge clk);
      #1;
      if (i < 5) drive0(v0[i+1]);
      else       bus0.ReqValid = 1'b0;
      @(negedge clk);
      check($sformatf("ws0[%0d].resp_valid", i), {31'b0, bus0.RspValid}, 32'd1);
      check($sformatf("ws0[%0d].resp_ready", i), {31'b0, bus0.ReqReady}, 32'd0);
      check($sformatf("ws0[%0d].resp_stall", i), {31'b0, bus0.Stall},    32'd0);
      check($sformatf("ws0[%0d].rdata", i),      bus0.RspRData,          v0[i].exp_rdata);
      check($sformatf("ws0[%0d].err", i),        {31'b0, bus0.RspErr},   {31'b0, v0[i].exp_err});
    end
    @(negedge clk);
    check("ws0.final_valid", {31'b0, bus0.RspValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_data_mem_responder
